// File: rtl/xadc_drp_scheduler.sv
// -----------------------------------------------------------------------------
// xadc_drp_scheduler
//
// Owns the XADC DRP port. After reset it writes one configuration word, then
// reads the next auxiliary channel from a round-robin table on every
// end-of-conversion. Each read result is exported as a 12-bit code, both as a
// one-cycle sample strobe and as a per-slot "last value" bus. A single
// external register-write requester shares the same DRP bus.
//
// Ports
//   clk_i            system clock, also drives the XADC dclk
//   rst_ni           asynchronous active-low reset
//   eoc_i            XADC end-of-conversion pulse
//   drp_den_o        DRP enable, one-cycle pulse per transaction
//   drp_dwe_o        DRP write enable, valid with drp_den_o
//   drp_daddr_o      DRP address, held for the whole transaction
//   drp_di_o         DRP write data
//   drp_do_i         DRP read data, valid with drp_drdy_i
//   drp_drdy_i       DRP transaction done
//   cfg_req_i        external write request (level, held until cfg_ack_o)
//   cfg_addr_i       external write address
//   cfg_data_i       external write data
//   cfg_ack_o        one-cycle pulse: external write finished or timed out
//   sample_valid_o   one-cycle pulse: new sample on sample_ch_o/sample_data_o
//   sample_ch_o      table slot of the sample
//   sample_data_o    drp_do_i[15:4] of the read
//   ch_data_o        last sample per slot, slot 0 in bits [11:0]
//   busy_o           a DRP transaction is outstanding
//   timeout_err_o    sticky: some transaction never saw drp_drdy_i
//   overrun_err_o    sticky: an eoc arrived while another was still pending
// -----------------------------------------------------------------------------
module xadc_drp_scheduler #(
    parameter int unsigned         NUM_CH    = 4,
    parameter logic [7*NUM_CH-1:0] CH_ADDR   = {7'h1F, 7'h1E, 7'h17, 7'h16},
    parameter logic [6:0]          CFG1_ADDR = 7'h41,
    parameter logic [15:0]         CFG1_INIT = 16'h2000,
    parameter int unsigned         TIMEOUT   = 63
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  eoc_i,
    output logic                  drp_den_o,
    output logic                  drp_dwe_o,
    output logic [6:0]            drp_daddr_o,
    output logic [15:0]           drp_di_o,
    input  logic [15:0]           drp_do_i,
    input  logic                  drp_drdy_i,
    input  logic                  cfg_req_i,
    input  logic [6:0]            cfg_addr_i,
    input  logic [15:0]           cfg_data_i,
    output logic                  cfg_ack_o,
    output logic                  sample_valid_o,
    output logic [1:0]            sample_ch_o,
    output logic [11:0]           sample_data_o,
    output logic [12*NUM_CH-1:0]  ch_data_o,
    output logic                  busy_o,
    output logic                  timeout_err_o,
    output logic                  overrun_err_o
);

    typedef enum logic [2:0] {
        ST_INIT_WR,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_RD_WAIT,
        ST_CFG_WAIT
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] PTR_LAST = 2'(NUM_CH - 1);

    state_e               state_q,        state_d;
    logic                 den_q,          den_d;
    logic                 dwe_q,          dwe_d;
    logic [6:0]           daddr_q,        daddr_d;
    logic [15:0]          di_q,           di_d;
    logic                 busy_q,         busy_d;
    logic [7:0]           waitCnt_q,      waitCnt_d;
    logic [1:0]           ptr_q,          ptr_d;
    logic                 eocPend_q,      eocPend_d;
    logic                 tieCfg_q,       tieCfg_d;
    logic                 cfgAck_q,       cfgAck_d;
    logic                 sampleValid_q,  sampleValid_d;
    logic [1:0]           sampleCh_q,     sampleCh_d;
    logic [11:0]          sampleData_q,   sampleData_d;
    logic [12*NUM_CH-1:0] chData_q,       chData_d;
    logic                 timeoutErr_q,   timeoutErr_d;
    logic                 overrunErr_q,   overrunErr_d;

    logic rdReq;
    logic grantRd;
    logic grantCfg;
    logic waitDone;
    logic waitExpired;

    // The low nibble of the DRP read word carries no information for the
    // 12-bit consumers downstream, so it is deliberately dropped here.
    logic unusedDoLsb;
    assign unusedDoLsb = ^drp_do_i[3:0];

    // Next-state and output logic. Every DRP output is registered so that all
    // outputs are 0 while reset is held and a grant decided on one clock edge
    // shows up on drp_den_o in the very next cycle.
    //
    // Arbitration: when a read and an external write want the bus on the same
    // edge, tieCfg_q decides and then flips, so ties alternate starting with a
    // read. Grants without competition leave the tie order alone.
    //
    // The wait counter is cleared when a transaction is granted and counts
    // each cycle spent waiting; reaching TIMEOUT cycles without drp_drdy_i
    // abandons the transaction so the scan can never stall.
    always_comb begin
        state_d       = state_q;
        den_d         = 1'b0;
        dwe_d         = dwe_q;
        daddr_d       = daddr_q;
        di_d          = di_q;
        busy_d        = busy_q;
        waitCnt_d     = waitCnt_q;
        ptr_d         = ptr_q;
        eocPend_d     = eocPend_q;
        tieCfg_d      = tieCfg_q;
        cfgAck_d      = 1'b0;
        sampleValid_d = 1'b0;
        sampleCh_d    = sampleCh_q;
        sampleData_d  = sampleData_q;
        chData_d      = chData_q;
        timeoutErr_d  = timeoutErr_q;
        overrunErr_d  = overrunErr_q;

        rdReq       = eocPend_q | eoc_i;
        grantRd     = 1'b0;
        grantCfg    = 1'b0;
        waitDone    = drp_drdy_i;
        waitExpired = !drp_drdy_i && (waitCnt_q == TMO_LAST);

        case (state_q)
            ST_INIT_WR: begin
                den_d     = 1'b1;
                dwe_d     = 1'b1;
                daddr_d   = CFG1_ADDR;
                di_d      = CFG1_INIT;
                busy_d    = 1'b1;
                waitCnt_d = 8'd0;
                state_d   = ST_INIT_WAIT;
            end

            ST_INIT_WAIT: begin
                if (waitDone || waitExpired) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (waitExpired) begin
                        timeoutErr_d = 1'b1;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end

            ST_IDLE: begin
                if (rdReq && cfg_req_i) begin
                    grantCfg = tieCfg_q;
                    grantRd  = !tieCfg_q;
                    tieCfg_d = !tieCfg_q;
                end else begin
                    grantRd  = rdReq;
                    grantCfg = cfg_req_i;
                end

                if (eocPend_q && eoc_i) begin
                    overrunErr_d = 1'b1;
                end

                if (grantRd) begin
                    den_d     = 1'b1;
                    dwe_d     = 1'b0;
                    daddr_d   = CH_ADDR[7*int'(ptr_q) +: 7];
                    eocPend_d = 1'b0;
                    busy_d    = 1'b1;
                    waitCnt_d = 8'd0;
                    state_d   = ST_RD_WAIT;
                end else if (grantCfg) begin
                    den_d     = 1'b1;
                    dwe_d     = 1'b1;
                    daddr_d   = cfg_addr_i;
                    di_d      = cfg_data_i;
                    eocPend_d = rdReq;
                    busy_d    = 1'b1;
                    waitCnt_d = 8'd0;
                    state_d   = ST_CFG_WAIT;
                end
            end

            ST_RD_WAIT, ST_CFG_WAIT: begin
                if (eoc_i) begin
                    if (eocPend_q) begin
                        overrunErr_d = 1'b1;
                    end
                    eocPend_d = 1'b1;
                end

                if (waitDone || waitExpired) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (waitExpired) begin
                        timeoutErr_d = 1'b1;
                    end
                    if (state_q == ST_RD_WAIT) begin
                        ptr_d = (ptr_q == PTR_LAST) ? 2'd0 : ptr_q + 2'd1;
                        if (waitDone) begin
                            sampleValid_d = 1'b1;
                            sampleCh_d    = ptr_q;
                            sampleData_d  = drp_do_i[15:4];
                            chData_d[12*int'(ptr_q) +: 12] = drp_do_i[15:4];
                        end
                    end else begin
                        cfgAck_d = 1'b1;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_INIT_WR;
            end
        endcase
    end

    // State and output registers. Reset aborts any outstanding transaction
    // without an acknowledge and restarts from the configuration write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_INIT_WR;
            den_q         <= 1'b0;
            dwe_q         <= 1'b0;
            daddr_q       <= 7'd0;
            di_q          <= 16'd0;
            busy_q        <= 1'b0;
            waitCnt_q     <= 8'd0;
            ptr_q         <= 2'd0;
            eocPend_q     <= 1'b0;
            tieCfg_q      <= 1'b0;
            cfgAck_q      <= 1'b0;
            sampleValid_q <= 1'b0;
            sampleCh_q    <= 2'd0;
            sampleData_q  <= 12'd0;
            chData_q      <= '0;
            timeoutErr_q  <= 1'b0;
            overrunErr_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            den_q         <= den_d;
            dwe_q         <= dwe_d;
            daddr_q       <= daddr_d;
            di_q          <= di_d;
            busy_q        <= busy_d;
            waitCnt_q     <= waitCnt_d;
            ptr_q         <= ptr_d;
            eocPend_q     <= eocPend_d;
            tieCfg_q      <= tieCfg_d;
            cfgAck_q      <= cfgAck_d;
            sampleValid_q <= sampleValid_d;
            sampleCh_q    <= sampleCh_d;
            sampleData_q  <= sampleData_d;
            chData_q      <= chData_d;
            timeoutErr_q  <= timeoutErr_d;
            overrunErr_q  <= overrunErr_d;
        end
    end

    assign drp_den_o      = den_q;
    assign drp_dwe_o      = dwe_q;
    assign drp_daddr_o    = daddr_q;
    assign drp_di_o       = di_q;
    assign cfg_ack_o      = cfgAck_q;
    assign sample_valid_o = sampleValid_q;
    assign sample_ch_o    = sampleCh_q;
    assign sample_data_o  = sampleData_q;
    assign ch_data_o      = chData_q;
    assign busy_o         = busy_q;
    assign timeout_err_o  = timeoutErr_q;
    assign overrun_err_o  = overrunErr_q;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_xadc_drp_scheduler
//
// Directed and randomized bench for xadc_drp_scheduler. The bench plays the
// XADC DRP slave and the external write requester, and keeps its own picture
// of the scheduler: which table slot is read next, the last code per slot and
// who wins the next read/write tie.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xadc_drp_scheduler;

    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 63;

    logic                 clk = 1'b0;
    logic                 rstN;
    logic                 eoc;
    logic                 drpDen;
    logic                 drpDwe;
    logic [6:0]           drpDaddr;
    logic [15:0]          drpDi;
    logic [15:0]          drpDo;
    logic                 drpDrdy;
    logic                 cfgReq;
    logic [6:0]           cfgAddr;
    logic [15:0]          cfgData;
    logic                 cfgAck;
    logic                 sampleValid;
    logic [1:0]           sampleCh;
    logic [11:0]          sampleData;
    logic [12*NUM_CH-1:0] chData;
    logic                 busy;
    logic                 timeoutErr;
    logic                 overrunErr;

    int errors = 0;
    int checks = 0;

    logic [6:0]  chAddr [NUM_CH];
    logic [11:0] modelCh [NUM_CH];
    int          modelPtr;
    logic        nextTieIsCfg;

    xadc_drp_scheduler #(
        .NUM_CH  (NUM_CH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .eoc_i          (eoc),
        .drp_den_o      (drpDen),
        .drp_dwe_o      (drpDwe),
        .drp_daddr_o    (drpDaddr),
        .drp_di_o       (drpDi),
        .drp_do_i       (drpDo),
        .drp_drdy_i     (drpDrdy),
        .cfg_req_i      (cfgReq),
        .cfg_addr_i     (cfgAddr),
        .cfg_data_i     (cfgData),
        .cfg_ack_o      (cfgAck),
        .sample_valid_o (sampleValid),
        .sample_ch_o    (sampleCh),
        .sample_data_o  (sampleData),
        .ch_data_o      (chData),
        .busy_o         (busy),
        .timeout_err_o  (timeoutErr),
        .overrun_err_o  (overrunErr)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case a task ever loses track of the DUT.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the eoc pulse and the cfg request level, then move to the next
    // falling edge; eoc is a pulse so it drops again there.
    task automatic applyStimulus(input logic eocVal, input logic reqVal);
        eoc    = eocVal;
        cfgReq = reqVal;
        @(negedge clk);
        eoc = 1'b0;
    endtask

    // Expected per-slot bus built from the bench's own table of last codes.
    function automatic logic [63:0] packModel();
        logic [63:0] word;
        word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            word[12*i +: 12] = modelCh[i];
        end
        return word;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < NUM_CH; i++) begin
            modelCh[i] = 12'd0;
        end
        modelPtr     = 0;
        nextTieIsCfg = 1'b0;
    endfunction

    // Called in the cycle where a new transaction should have started.
    task automatic checkGrant(input logic isWrite, input logic [6:0] addr, input logic [15:0] data);
        checkOutput("grant_den", 64'(drpDen), 64'(1));
        checkOutput("grant_dwe", 64'(drpDwe), 64'(isWrite));
        checkOutput("grant_addr", 64'(drpDaddr), 64'(addr));
        if (isWrite) begin
            checkOutput("grant_di", 64'(drpDi), 64'(data));
        end
        checkOutput("grant_busy", 64'(busy), 64'(1));
    endtask

    // Answer the outstanding transaction 'lat' cycles after its den cycle and
    // stop in the cycle right after drp_drdy was seen.
    task automatic completeDrp(input int lat, input logic [15:0] rdata);
        repeat (lat) @(negedge clk);
        drpDrdy = 1'b1;
        drpDo   = rdata;
        checkOutput("busy_wait", 64'(busy), 64'(1));
        @(negedge clk);
        drpDrdy = 1'b0;
        drpDo   = 16'($urandom);
        checkOutput("busy_done", 64'(busy), 64'(0));
    endtask

    // Called in the cycle after a completed read.
    task automatic checkSample(input logic [15:0] rdata);
        checkOutput("sample_valid", 64'(sampleValid), 64'(1));
        checkOutput("sample_ch", 64'(sampleCh), 64'(modelPtr));
        checkOutput("sample_data", 64'(sampleData), 64'(rdata[15:4]));
        modelCh[modelPtr] = rdata[15:4];
        checkOutput("ch_data", 64'(chData), packModel());
        modelPtr = (modelPtr + 1) % NUM_CH;
    endtask

    task automatic doRead(input logic [15:0] rdata, input int lat);
        applyStimulus(1'b1, 1'b0);
        checkGrant(1'b0, chAddr[modelPtr], 16'd0);
        completeDrp(lat, rdata);
        checkSample(rdata);
    endtask

    task automatic doCfg(input logic [6:0] addr, input logic [15:0] data, input int lat);
        cfgAddr = addr;
        cfgData = data;
        applyStimulus(1'b0, 1'b1);
        checkGrant(1'b1, addr, data);
        completeDrp(lat, 16'($urandom));
        checkOutput("cfg_ack", 64'(cfgAck), 64'(1));
        cfgReq = 1'b0;
        @(negedge clk);
        checkOutput("cfg_ack_pulse", 64'(cfgAck), 64'(0));
        checkOutput("cfg_no_regrant", 64'(drpDen), 64'(0));
    endtask

    // eoc and cfg_req together: the winner follows the bench's tie order,
    // the loser is served straight afterwards.
    task automatic doTie(input logic [6:0] addr, input logic [15:0] data, input logic [15:0] rdata);
        cfgAddr = addr;
        cfgData = data;
        applyStimulus(1'b1, 1'b1);
        if (nextTieIsCfg) begin
            checkGrant(1'b1, addr, data);
            completeDrp($urandom_range(1, 5), 16'($urandom));
            checkOutput("tie_cfg_ack", 64'(cfgAck), 64'(1));
            cfgReq = 1'b0;
            @(negedge clk);
            checkGrant(1'b0, chAddr[modelPtr], 16'd0);
            completeDrp($urandom_range(1, 5), rdata);
            checkSample(rdata);
        end else begin
            checkGrant(1'b0, chAddr[modelPtr], 16'd0);
            completeDrp($urandom_range(1, 5), rdata);
            checkSample(rdata);
            @(negedge clk);
            checkGrant(1'b1, addr, data);
            completeDrp($urandom_range(1, 5), 16'($urandom));
            checkOutput("tie_cfg_ack", 64'(cfgAck), 64'(1));
            cfgReq = 1'b0;
        end
        nextTieIsCfg = !nextTieIsCfg;
        @(negedge clk);
        checkOutput("tie_quiet", 64'(drpDen), 64'(0));
    endtask

    // Start a transaction the slave never answers and measure how long the
    // scheduler stays busy, then throw a late drdy at it.
    task automatic doTimeout(input logic isCfg);
        int   busyCycles;
        logic sawSample;
        if (isCfg) begin
            cfgAddr = 7'($urandom);
            cfgData = 16'($urandom);
            applyStimulus(1'b0, 1'b1);
            checkGrant(1'b1, cfgAddr, cfgData);
        end else begin
            applyStimulus(1'b1, 1'b0);
            checkGrant(1'b0, chAddr[modelPtr], 16'd0);
        end
        busyCycles = 0;
        sawSample  = 1'b0;
        while (busy === 1'b1 && busyCycles < 300) begin
            busyCycles++;
            if (sampleValid === 1'b1) sawSample = 1'b1;
            @(negedge clk);
        end
        checkOutput("tmo_cycles", 64'(busyCycles), 64'(TIMEOUT));
        checkOutput("tmo_err", 64'(timeoutErr), 64'(1));
        if (isCfg) begin
            checkOutput("tmo_cfg_ack", 64'(cfgAck), 64'(1));
            cfgReq = 1'b0;
        end else begin
            checkOutput("tmo_no_sample", 64'(sawSample | sampleValid), 64'(0));
            modelPtr = (modelPtr + 1) % NUM_CH;
        end
        drpDrdy = 1'b1;
        drpDo   = 16'($urandom);
        @(negedge clk);
        drpDrdy = 1'b0;
        checkOutput("late_drdy_sample", 64'(sampleValid), 64'(0));
        checkOutput("late_drdy_den", 64'(drpDen), 64'(0));
        checkOutput("late_drdy_ack", 64'(cfgAck), 64'(0));
    endtask

    initial begin
        int denSeen;

        chAddr  = '{7'h16, 7'h17, 7'h1E, 7'h1F};
        rstN    = 1'b0;
        eoc     = 1'b0;
        drpDrdy = 1'b0;
        drpDo   = 16'd0;
        cfgReq  = 1'b0;
        cfgAddr = 7'd0;
        cfgData = 16'd0;
        modelReset();

        // Reset state and the configuration write after release.
        repeat (2) @(negedge clk);
        checkOutput("rst_den", 64'(drpDen), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_addr", 64'(drpDaddr), 64'(0));
        checkOutput("rst_ch_data", 64'(chData), 64'(0));
        checkOutput("rst_valid", 64'(sampleValid), 64'(0));
        checkOutput("rst_errs", 64'({timeoutErr, overrunErr, cfgAck}), 64'(0));
        rstN = 1'b1;
        @(negedge clk);
        checkGrant(1'b1, 7'h41, 16'h2000);
        @(negedge clk);
        checkOutput("init_den_pulse", 64'(drpDen), 64'(0));
        completeDrp(2, 16'($urandom));
        @(negedge clk);
        checkOutput("init_idle_den", 64'(drpDen), 64'(0));
        checkOutput("init_idle_busy", 64'(busy), 64'(0));

        // Round-robin scan, then wrap back to slot 0.
        doRead(16'hABC0, 2);
        doRead(16'h1230, 1);
        doRead(16'hFFF0, 4);
        doRead(16'h0000, 3);
        doRead(16'($urandom), 2);

        // Read/write ties alternate, first one going to the read.
        doTie(7'h42, 16'h0400, 16'($urandom));
        doTie(7'($urandom), 16'($urandom), 16'($urandom));
        doTie(7'($urandom), 16'($urandom), 16'($urandom));

        // Unanswered read and unanswered write.
        checkOutput("tmo_err_before", 64'(timeoutErr), 64'(0));
        doTimeout(1'b0);
        doTimeout(1'b1);
        doRead(16'($urandom), 2);

        // Three eoc pulses during one read collapse into one follow-up read.
        checkOutput("ovr_before", 64'(overrunErr), 64'(0));
        begin
            logic [15:0] first;
            logic [15:0] second;
            first  = 16'($urandom);
            second = 16'($urandom);
            applyStimulus(1'b1, 1'b0);
            checkGrant(1'b0, chAddr[modelPtr], 16'd0);
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0);
            completeDrp(2, first);
            checkSample(first);
            checkOutput("ovr_set", 64'(overrunErr), 64'(1));
            @(negedge clk);
            checkGrant(1'b0, chAddr[modelPtr], 16'd0);
            completeDrp(3, second);
            checkSample(second);
            denSeen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (drpDen === 1'b1) denSeen++;
            end
            checkOutput("ovr_single_followup", 64'(denSeen), 64'(0));
        end

        // Randomized mix of reads, writes and ties.
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0:       doRead(16'($urandom), $urandom_range(1, 6));
                1:       doCfg(7'($urandom), 16'($urandom), $urandom_range(1, 6));
                default: doTie(7'($urandom), 16'($urandom), 16'($urandom));
            endcase
        end

        // Reset in the middle of a read: outputs clear at once, the
        // configuration write repeats and the aborted read never reports.
        applyStimulus(1'b1, 1'b0);
        checkGrant(1'b0, chAddr[modelPtr], 16'd0);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_ch_data", 64'(chData), 64'(0));
        checkOutput("abort_flags", 64'({timeoutErr, overrunErr, sampleValid, cfgAck, drpDen}), 64'(0));
        drpDrdy = 1'b1;
        drpDo   = 16'h5550;
        @(negedge clk);
        drpDrdy = 1'b0;
        rstN    = 1'b1;
        modelReset();
        @(negedge clk);
        checkGrant(1'b1, 7'h41, 16'h2000);
        checkOutput("reinit_no_sample", 64'(sampleValid), 64'(0));
        applyStimulus(1'b1, 1'b0);
        completeDrp(2, 16'($urandom));
        checkOutput("reinit_done_no_sample", 64'(sampleValid), 64'(0));
        denSeen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (drpDen === 1'b1) denSeen++;
        end
        checkOutput("init_eoc_dropped", 64'(denSeen), 64'(0));
        doRead(16'($urandom), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
